// File: rtl/axi_slv_arb2.sv
// axi_slv_arb2: two-master to one-slave AXI4 arbiter for a single-beat memory.
// Read and write paths arbitrate independently. Each path has its own
// round-robin priority and allows one outstanding transaction. The granted
// master index becomes the MSB of the slave-side ID. Responses are routed back
// using the registered grant.
module axi_slv_arb2 #(
  parameter int TAGW = 1
) (
  input  logic                aclk,
  input  logic                rst,

  // master-side read address / data
  input  logic [1:0]          m_arvalid,
  output logic [1:0]          m_arready,
  input  logic [63:0]         m_araddr,
  input  logic [2*TAGW-1:0]   m_arid,
  output logic [1:0]          m_rvalid,
  input  logic [1:0]          m_rready,
  output logic [63:0]         m_rdata,
  output logic [1:0]          m_rresp,
  output logic [TAGW-1:0]     m_rid,
  output logic                m_rlast,

  // master-side write address / data / response
  input  logic [1:0]          m_awvalid,
  output logic [1:0]          m_awready,
  input  logic [1:0]          m_wvalid,
  output logic [1:0]          m_wready,
  input  logic [63:0]         m_awaddr,
  input  logic [2*TAGW-1:0]   m_awid,
  input  logic [127:0]        m_wdata,
  input  logic [15:0]         m_wstrb,
  output logic [1:0]          m_bvalid,
  input  logic [1:0]          m_bready,
  output logic [1:0]          m_bresp,
  output logic [TAGW-1:0]     m_bid,

  // slave-side read address / data
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [31:0]         s_araddr,
  output logic [TAGW:0]       s_arid,
  output logic [7:0]          s_arlen,
  output logic [1:0]          s_arburst,
  output logic [2:0]          s_arsize,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [63:0]         s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic [TAGW:0]       s_rid,
  input  logic                s_rlast,

  // slave-side write address / data / response
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [31:0]         s_awaddr,
  output logic [TAGW:0]       s_awid,
  output logic [7:0]          s_awlen,
  output logic [1:0]          s_awburst,
  output logic [2:0]          s_awsize,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [63:0]         s_wdata,
  output logic [7:0]          s_wstrb,
  output logic                s_wlast,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  input  logic [TAGW:0]       s_bid
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Pick a winner. A lone requester wins outright. On a tie, pri decides.
  function automatic logic arb_pick(input logic [1:0] req, input logic pri);
    if (req == 2'b11) return pri;
    return req[1];
  endfunction

  function automatic logic [31:0] sel32(input logic [63:0] v, input logic i);
    return i ? v[63:32] : v[31:0];
  endfunction

  function automatic logic [63:0] sel64(input logic [127:0] v, input logic i);
    return i ? v[127:64] : v[63:0];
  endfunction

  function automatic logic [7:0] sel8(input logic [15:0] v, input logic i);
    return i ? v[15:8] : v[7:0];
  endfunction

  function automatic logic [TAGW-1:0] sel_id(input logic [2*TAGW-1:0] v, input logic i);
    return i ? v[2*TAGW-1:TAGW] : v[TAGW-1:0];
  endfunction

  // Fixed single-beat, incrementing, 8-byte bursts.
  assign s_arlen   = 8'd0;
  assign s_arburst = 2'b01;
  assign s_arsize  = 3'b011;
  assign s_awlen   = 8'd0;
  assign s_awburst = 2'b01;
  assign s_awsize  = 3'b011;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t r_state;
  logic     rg;
  logic     rpri;
  logic     r_win;
  logic     r_in_addr;
  logic     r_in_data;
  logic [1:0] r_oh;

  assign r_win     = arb_pick(m_arvalid, rpri);
  assign r_in_addr = (r_state == R_ADDR);
  assign r_in_data = (r_state == R_DATA);
  assign r_oh      = {rg, ~rg};

  // Read FSM: grant in IDLE, issue the address, then wait for the last data beat.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state  <= R_IDLE;
      rg       <= 1'b0;
      rpri     <= 1'b0;
      s_araddr <= '0;
      s_arid   <= '0;
    end else begin
      // NOTE: Sequential state uses non-blocking assignments. This lets every
      // register in the block sample the pre-edge values of the others.
      case (r_state)
        R_IDLE: begin
          if (|m_arvalid) begin
            // NOTE: The payload is captured at grant time. This is safe
            // because AXI masters hold it stable until ready.
            rg       <= r_win;
            s_araddr <= sel32(m_araddr, r_win);
            s_arid   <= {r_win, sel_id(m_arid, r_win)};
            r_state  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (s_arready) begin
            s_araddr <= '0;
            s_arid   <= '0;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rvalid && s_rready && s_rlast) begin
            rpri    <= ~rg;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_arvalid = r_in_addr;
  assign m_arready = {2{r_in_addr & s_arready}} & r_oh;
  assign s_rready  = r_in_data & m_rready[rg];
  assign m_rvalid  = {2{r_in_data & s_rvalid}} & r_oh;
  assign m_rdata   = r_in_data ? s_rdata : '0;
  assign m_rid     = r_in_data ? s_rid[TAGW-1:0] : '0;
  assign m_rlast   = r_in_data & s_rlast;
  assign m_rresp   = !r_in_data            ? 2'b00 :
                     (s_rid[TAGW] != rg)   ? RESP_SLVERR : s_rresp;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t w_state;
  logic     wg;
  logic     wpri;
  logic     aw_done;
  logic     w_done;
  logic [1:0] w_req;
  logic     w_win;
  logic     w_in_addr;
  logic     w_in_resp;
  logic     aw_hs;
  logic     w_hs;
  logic [1:0] w_oh;

  assign w_req     = m_awvalid & m_wvalid;
  assign w_win     = arb_pick(w_req, wpri);
  assign w_in_addr = (w_state == W_ADDR);
  assign w_in_resp = (w_state == W_RESP);
  assign w_oh      = {wg, ~wg};

  assign s_awvalid = w_in_addr & ~aw_done;
  assign s_wvalid  = w_in_addr & ~w_done;
  assign s_wlast   = s_wvalid;
  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;

  // Write FSM: grant in IDLE, then collect the AW and W handshakes in any order,
  // then wait for the write response.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      w_state  <= W_IDLE;
      wg       <= 1'b0;
      wpri     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      s_awaddr <= '0;
      s_awid   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (|w_req) begin
            wg       <= w_win;
            s_awaddr <= sel32(m_awaddr, w_win);
            s_awid   <= {w_win, sel_id(m_awid, w_win)};
            s_wdata  <= sel64(m_wdata, w_win);
            s_wstrb  <= sel8(m_wstrb, w_win);
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            w_state  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            s_awaddr <= '0;
            s_awid   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            w_state  <= W_RESP;
          end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
          end
        end
        W_RESP: begin
          if (s_bvalid && s_bready) begin
            wpri    <= ~wg;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign m_awready = {2{aw_hs}} & w_oh;
  assign m_wready  = {2{w_hs}} & w_oh;
  assign s_bready  = w_in_resp & m_bready[wg];
  assign m_bvalid  = {2{w_in_resp & s_bvalid}} & w_oh;
  assign m_bid     = w_in_resp ? s_bid[TAGW-1:0] : '0;
  assign m_bresp   = !w_in_resp            ? 2'b00 :
                     (s_bid[TAGW] != wg)   ? RESP_SLVERR : s_bresp;

endmodule

// File: tb/tb_axi_slv_arb2.sv
// Testbench for axi_slv_arb2. Master expectations are pushed to scoreboard
// queues when a request is driven. They are popped and compared while the
// bench plays the slave and the response is routed back.
module tb_axi_slv_arb2;

  localparam int TAGW = 1;

  logic                aclk = 1'b0;
  logic                rst;
  logic [1:0]          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0]         m_araddr, m_rdata;
  logic [2*TAGW-1:0]   m_arid;
  logic [1:0]          m_rresp;
  logic [TAGW-1:0]     m_rid;
  logic                m_rlast;
  logic [1:0]          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [63:0]         m_awaddr;
  logic [2*TAGW-1:0]   m_awid;
  logic [127:0]        m_wdata;
  logic [15:0]         m_wstrb;
  logic [1:0]          m_bresp;
  logic [TAGW-1:0]     m_bid;
  logic                s_arvalid, s_arready;
  logic [31:0]         s_araddr;
  logic [TAGW:0]       s_arid;
  logic [7:0]          s_arlen;
  logic [1:0]          s_arburst;
  logic [2:0]          s_arsize;
  logic                s_rvalid, s_rready, s_rlast;
  logic [63:0]         s_rdata;
  logic [1:0]          s_rresp;
  logic [TAGW:0]       s_rid;
  logic                s_awvalid, s_awready;
  logic [31:0]         s_awaddr;
  logic [TAGW:0]       s_awid;
  logic [7:0]          s_awlen;
  logic [1:0]          s_awburst;
  logic [2:0]          s_awsize;
  logic                s_wvalid, s_wready, s_wlast;
  logic [63:0]         s_wdata;
  logic [7:0]          s_wstrb;
  logic                s_bvalid, s_bready;
  logic [1:0]          s_bresp;
  logic [TAGW:0]       s_bid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int              m;
    logic [31:0]     addr;
    logic [TAGW-1:0] id;
    logic [63:0]     data;
    logic            bad;
    logic [1:0]      resp;
  } rexp_t;

  typedef struct {
    int              m;
    logic [31:0]     addr;
    logic [TAGW-1:0] id;
    logic [63:0]     data;
    logic [7:0]      strb;
    logic            bad;
    logic [1:0]      resp;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];

  axi_slv_arb2 #(.TAGW(TAGW)) dut (
    .aclk(aclk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Concatenation of every non-constant DUT output; all zero when idle or in reset.
  function automatic logic [288:0] all_outs();
    return {m_arready, m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
            m_awready, m_wready, m_bvalid, m_bresp, m_bid,
            s_arvalid, s_araddr, s_arid, s_rready,
            s_awvalid, s_awaddr, s_awid, s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready};
  endfunction

  task automatic start_read(input int m, input logic [31:0] addr, input logic [TAGW-1:0] id,
                            input logic [63:0] data, input logic bad);
    rexp_t e;
    m_arvalid[m] = 1'b1;
    m_araddr[m*32 +: 32] = addr;
    m_arid[m*TAGW +: TAGW] = id;
    e.m = m; e.addr = addr; e.id = id; e.data = data; e.bad = bad;
    e.resp = bad ? 2'b10 : 2'b00;
    rq.push_back(e);
  endtask

  task automatic start_write(input int m, input logic [31:0] addr, input logic [TAGW-1:0] id,
                             input logic [63:0] data, input logic [7:0] strb, input logic bad);
    wexp_t e;
    m_awvalid[m] = 1'b1;
    m_wvalid[m]  = 1'b1;
    m_awaddr[m*32 +: 32] = addr;
    m_awid[m*TAGW +: TAGW] = id;
    m_wdata[m*64 +: 64] = data;
    m_wstrb[m*8 +: 8] = strb;
    e.m = m; e.addr = addr; e.id = id; e.data = data; e.strb = strb; e.bad = bad;
    e.resp = bad ? 2'b10 : 2'b00;
    wq.push_back(e);
  endtask

  // Slave side of one read: accept the address, return one beat and check the routing.
  task automatic serve_read();
    rexp_t e;
    logic [1:0] oh;
    logic msb;
    int n = 0;
    while (s_arvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (s_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL ar_wait: s_arvalid=%b required 1 within 20 cycles", s_arvalid);
      return;
    end
    e = rq.pop_front();
    oh = (e.m == 1) ? 2'b10 : 2'b01;
    checks++;
    if ({s_arid, s_araddr} !== {e.m[0], e.id, e.addr}) begin
      errors++;
      $display("FAIL ar_fields: s_arid=%h s_araddr=%h required %h %h",
               s_arid, s_araddr, {e.m[0], e.id}, e.addr);
    end
    s_arready = 1'b1;
    #1;
    checks++;
    if (m_arready !== oh) begin
      errors++;
      $display("FAIL ar_ready: m_arready=%b required %b", m_arready, oh);
    end
    @(negedge aclk);
    s_arready = 1'b0;
    m_arvalid[e.m] = 1'b0;
    msb = e.bad ? ~e.m[0] : e.m[0];
    s_rvalid = 1'b1; s_rdata = e.data; s_rid = {msb, e.id}; s_rresp = 2'b00; s_rlast = 1'b1;
    #1;
    checks++;
    if ({m_rvalid, s_rready, m_rdata, m_rresp, m_rid, m_rlast} !==
        {oh, 1'b1, e.data, e.resp, e.id, 1'b1}) begin
      errors++;
      $display("FAIL r_route: m_rvalid=%b s_rready=%b m_rdata=%h m_rresp=%b m_rid=%h required %b 1 %h %b %h",
               m_rvalid, s_rready, m_rdata, m_rresp, m_rid, oh, e.data, e.resp, e.id);
    end
    @(negedge aclk);
    s_rvalid = 1'b0; s_rdata = '0; s_rid = '0; s_rlast = 1'b0;
    #1;
    checks++;
    if ({m_rvalid, s_rready, s_arvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL r_idle: m_rvalid=%b s_rready=%b s_arvalid=%b required 0",
               m_rvalid, s_rready, s_arvalid);
    end
  endtask

  // Slave side of one write: accept AW at offset 0 and W at offset split, then respond.
  task automatic serve_write(input int split);
    wexp_t e;
    logic [1:0] oh;
    logic msb;
    int n = 0;
    while (s_awvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (s_awvalid !== 1'b1) begin
      errors++;
      $display("FAIL aw_wait: s_awvalid=%b required 1 within 20 cycles", s_awvalid);
      return;
    end
    e = wq.pop_front();
    oh = (e.m == 1) ? 2'b10 : 2'b01;
    checks++;
    if ({s_awid, s_awaddr, s_wdata, s_wstrb} !== {e.m[0], e.id, e.addr, e.data, e.strb}) begin
      errors++;
      $display("FAIL aw_fields: s_awid=%h s_awaddr=%h s_wdata=%h s_wstrb=%h required %h %h %h %h",
               s_awid, s_awaddr, s_wdata, s_wstrb, {e.m[0], e.id}, e.addr, e.data, e.strb);
    end
    for (int c = 0; c <= split; c++) begin
      s_awready = (c == 0);
      s_wready  = (c == split);
      #1;
      checks++;
      if ({s_awvalid, s_wvalid, s_wlast, m_awready, m_wready} !==
          {(c == 0), 1'b1, 1'b1, (c == 0) ? oh : 2'b00, (c == split) ? oh : 2'b00}) begin
        errors++;
        $display("FAIL w_phase%0d: s_awvalid=%b s_wvalid=%b s_wlast=%b m_awready=%b m_wready=%b required %b 1 1 %b %b",
                 c, s_awvalid, s_wvalid, s_wlast, m_awready, m_wready,
                 (c == 0), (c == 0) ? oh : 2'b00, (c == split) ? oh : 2'b00);
      end
      @(negedge aclk);
      if (c == 0) m_awvalid[e.m] = 1'b0;
    end
    s_awready = 1'b0; s_wready = 1'b0;
    m_wvalid[e.m] = 1'b0;
    #1;
    checks++;
    if ({s_awvalid, s_wvalid, s_wlast} !== 3'b000) begin
      errors++;
      $display("FAIL w_drop: s_awvalid=%b s_wvalid=%b s_wlast=%b required 0",
               s_awvalid, s_wvalid, s_wlast);
    end
    msb = e.bad ? ~e.m[0] : e.m[0];
    s_bvalid = 1'b1; s_bid = {msb, e.id}; s_bresp = 2'b00;
    #1;
    checks++;
    if ({m_bvalid, s_bready, m_bresp, m_bid} !== {oh, 1'b1, e.resp, e.id}) begin
      errors++;
      $display("FAIL b_route: m_bvalid=%b s_bready=%b m_bresp=%b m_bid=%h required %b 1 %b %h",
               m_bvalid, s_bready, m_bresp, m_bid, oh, e.resp, e.id);
    end
    @(negedge aclk);
    s_bvalid = 1'b0; s_bid = '0;
    #1;
    checks++;
    if ({m_bvalid, s_bready} !== 3'b000) begin
      errors++;
      $display("FAIL b_idle: m_bvalid=%b s_bready=%b required 0", m_bvalid, s_bready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_arvalid = '0; m_araddr = '0; m_arid = '0; m_rready = 2'b11;
    m_awvalid = '0; m_wvalid = '0; m_awaddr = '0; m_awid = '0;
    m_wdata = '0; m_wstrb = '0; m_bready = 2'b11;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rid = '0; s_rlast = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0; s_bid = '0;
    repeat (3) @(negedge aclk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outs: outputs=%h required 0", all_outs());
    end
    checks++;
    if ({s_arlen, s_arburst, s_arsize, s_awlen, s_awburst, s_awsize} !==
        {8'd0, 2'b01, 3'b011, 8'd0, 2'b01, 3'b011}) begin
      errors++;
      $display("FAIL burst_consts: ar=%h/%b/%b aw=%h/%b/%b required 00/01/011",
               s_arlen, s_arburst, s_arsize, s_awlen, s_awburst, s_awsize);
    end
    rst = 1'b0;
    @(negedge aclk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: outputs=%h required 0", all_outs());
    end
  endtask

  // Both masters request on every opportunity; the grants must alternate 0,1,0.
  task automatic test_contention();
    start_read(0, 32'h0000_2000, 1'b0, 64'h1111_2222_3333_4444, 1'b0);
    start_read(1, 32'h0000_3000, 1'b1, 64'h5555_6666_7777_8888, 1'b0);
    serve_read();
    start_read(0, 32'h0000_2008, 1'b1, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
    serve_read();
    serve_read();
  endtask

  task automatic test_single_read();
    start_read(0, 32'h0000_1000, 1'b0, 64'hDEADBEEF_01234567, 1'b0);
    #1;
    checks++;
    if ({m_arready, s_arvalid} !== 3'b000) begin
      errors++;
      $display("FAIL ar_latency0: m_arready=%b s_arvalid=%b required 0 in request cycle",
               m_arready, s_arvalid);
    end
    @(negedge aclk);
    checks++;
    if (s_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL ar_latency1: s_arvalid=%b required 1 one cycle after request", s_arvalid);
    end
    serve_read();
  endtask

  task automatic test_write_split();
    start_write(0, 32'h0000_4000, 1'b1, 64'hCAFE_F00D_0BAD_BEEF, 8'hF0, 1'b0);
    serve_write(2);
  endtask

  task automatic test_id_mismatch();
    start_write(1, 32'h0000_5000, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    serve_write(0);
    start_read(1, 32'h0000_5008, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b1);
    serve_read();
  endtask

  // A read from m0 and a write from m1 in the same cycle proceed in parallel.
  task automatic test_concurrent();
    start_read(0, 32'h0000_6000, 1'b0, 64'hAAAA_0000_BBBB_0001, 1'b0);
    start_write(1, 32'h0000_6000, 1'b1, 64'h1234_0000_5678_0001, 8'h0F, 1'b0);
    @(negedge aclk);
    checks++;
    if ({s_arvalid, s_awvalid, s_wvalid} !== 3'b111) begin
      errors++;
      $display("FAIL concurrent: s_arvalid=%b s_awvalid=%b s_wvalid=%b required 111",
               s_arvalid, s_awvalid, s_wvalid);
    end
    serve_read();
    serve_write(0);
  endtask

  // Abort a read in R_DATA with reset. Later traffic must start from rpri=0.
  task automatic test_reset_mid_read();
    m_arvalid[0] = 1'b1;
    m_araddr[31:0] = 32'h0000_7000;
    m_arid[0] = 1'b0;
    @(negedge aclk);
    s_arready = 1'b1;
    @(negedge aclk);
    s_arready = 1'b0;
    m_arvalid[0] = 1'b0;
    s_rvalid = 1'b1; s_rdata = 64'h7777_7777_7777_7777; s_rid = '0; s_rlast = 1'b1;
    #1;
    checks++;
    if (m_rvalid !== 2'b01) begin
      errors++;
      $display("FAIL abort_setup: m_rvalid=%b required 01", m_rvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h required 0", all_outs());
    end
    @(negedge aclk);
    @(negedge aclk);
    rst = 1'b0;
    #1;
    checks++;
    if ({s_rready, m_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL stale_resp: s_rready=%b m_rvalid=%b required 0", s_rready, m_rvalid);
    end
    @(negedge aclk);
    s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
    start_read(0, 32'h0000_8000, 1'b0, 64'h0808_0808_0808_0808, 1'b0);
    start_read(1, 32'h0000_9000, 1'b1, 64'h0909_0909_0909_0909, 1'b0);
    serve_read();
    serve_read();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_write_split();
    test_id_mismatch();
    test_concurrent();
    test_reset_mid_read();
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: read left=%0d write left=%0d required 0",
               rq.size(), wq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_slv_arb2.md
# axi_slv_arb2

Two-master to one-slave AXI4 arbiter placed in front of the single-beat testbench memory slave, so that two requesters (e.g. instruction fetch and load/store ports) share one AXI memory. Read and write paths arbitrate independently with round-robin priority and at most one outstanding transaction per path. The granted master index is appended as the MSB of the slave-side ID, and responses are routed by the registered grant.

## Interface
Parameters:
- TAGW, 1, master-side ID width; slave-side ID width is TAGW+1.

Ports (index i ∈ {0,1}; packed master buses place master i at slice i):
- aclk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_arvalid / m_arready  in / out  2  per-master read-address handshake.
- m_araddr  in  64  read addresses, 32 bits per master.
- m_arid  in  2*TAGW  read IDs.
- m_rvalid / m_rready  out / in  2  per-master read-data handshake.
- m_rdata, m_rresp, m_rid, m_rlast  out  64, 2, TAGW, 1  shared read-response fields, passed from the slave.
- m_awvalid / m_awready, m_wvalid / m_wready  in / out  2 each  write-address and write-data handshakes.
- m_awaddr, m_awid, m_wdata, m_wstrb  in  64, 2*TAGW, 128, 16  write request fields.
- m_bvalid / m_bready  out / in  2  write-response handshake.
- m_bresp, m_bid  out  2, TAGW  shared write-response fields.
- s_arvalid / s_arready, s_araddr, s_arid  out / in, out, out  1, 32, TAGW+1  slave read address.
- s_arlen, s_arburst, s_arsize  out  8, 2, 3  constant 0, 2'b01, 3'b011.
- s_rvalid / s_rready, s_rdata, s_rresp, s_rid, s_rlast  in / out, in, in, in, in  1, 64, 2, TAGW+1, 1.
- s_awvalid / s_awready, s_awaddr, s_awid  out / in, out, out  1, 32, TAGW+1.
- s_awlen, s_awburst, s_awsize  out  constant 0, 2'b01, 3'b011.
- s_wvalid / s_wready, s_wdata, s_wstrb, s_wlast  out / in, out, out, out  1, 64, 8, 1 (s_wlast = s_wvalid).
- s_bvalid / s_bready, s_bresp, s_bid  in / out, in, in  1, 2, TAGW+1.

## Operation
- Read FSM, states R_IDLE → R_ADDR → R_DATA → R_IDLE:
  - R_IDLE: if any m_arvalid is set, register the grant rg and go to R_ADDR. Single requester wins outright. If both request, master rpri wins.
  - R_ADDR: s_arvalid=1; s_araddr and s_arid={rg, m_arid[rg]} are taken from the granted master; m_arready[rg]=s_arready. Leave on s_arvalid&s_arready.
  - R_DATA: m_rvalid[rg]=s_rvalid; s_rready=m_rready[rg]; m_rid=s_rid[TAGW-1:0]. Leave on s_rvalid&s_rready&s_rlast. On leaving, rpri ← ~rg.
- Write FSM, states W_IDLE → W_ADDR → W_RESP → W_IDLE:
  - A master requests only when both its awvalid and wvalid are set.
  - W_ADDR: s_awvalid and s_wvalid are driven by two flags, aw_done and w_done, each cleared on entry to W_ADDR. s_awvalid=~aw_done and s_wvalid=~w_done. Each flag sets on its own slave handshake, and m_awready/m_wready to the granted master mirror those handshakes. Go to W_RESP when both flags are done, including the case where both complete in the same cycle.
  - W_RESP: bvalid/bready routed to wg. Leave on s_bvalid&s_bready. On leaving, wpri ← ~wg.
- ID check on responses: if s_rid[TAGW] ≠ rg or s_bid[TAGW] ≠ wg, the response is still delivered to the granted master, with m_rresp/m_bresp forced to 2'b10 (SLVERR). Otherwise the slave resp passes through.
- Ungranted masters see ready=0 and valid=0.
- Read and write paths are fully independent. Simultaneous read and write to the same address is not ordered by this block.

## Timing
- Reset: FSMs go to IDLE, rpri=wpri=0 (master 0 favoured first), flags cleared. All valid/ready outputs are 0; s_* address, ID, data and strobe outputs are 0.
- Reset asserted mid-transaction: immediate abort. Any slave response arriving afterwards is ignored (s_rready=s_bready=0 while in IDLE).
- Arbitration latency is 1 cycle: m_arvalid high at cycle N gives s_arvalid high at N+1. With an always-ready slave, m_arready pulses at N+1.
- Returning to IDLE costs 1 cycle; back-to-back grants are therefore spaced by at least 1 idle cycle.
- Masters must hold valid and payload stable until ready (AXI rule). A master dropping arvalid while in R_ADDR is a protocol violation and the behaviour is undefined.

## Test plan
- Single read: m0 reads 0x1000, slave returns 0xDEADBEEF_01234567 with s_rid=0 → m_rvalid=2'b01 and data matches. m_arready[0] rises one cycle after m_arvalid[0].
- Contention: both masters issue reads in the same cycle, three times in a row → grants go 0,1,0; s_arid MSB follows the same sequence.
- Write with split acceptance: slave takes aw in cycle N and w in cycle N+2 → s_awvalid drops after N, s_wvalid holds until N+2. One bresp goes to the granted master; s_wlast=1 whenever s_wvalid=1.
- ID mismatch: grant master 1, slave returns s_bid MSB=0 → m_bvalid[1]=1 with m_bresp=2'b10.
- Reset mid-read: assert rst while in R_DATA → all outputs are 0 asynchronously; after release the next request from m1 is served normally with rpri=0.
- Concurrent read and write: m0 read and m1 write in the same cycle → both slave channels are active in the next cycle with no cross-blocking.
